// File: rtl/i2c_target_regs.sv
// I2C target exposing a NUM_REGS x 8 register file with an auto-incrementing pointer.
// Lines are synchronized and glitch-filtered; SDA is only ever pulled low or released.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         NUM_REGS    = 16,
  parameter int         FILTER_LEN  = 4,
  localparam int        PW          = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scl_i,
  output logic          scl_o,
  output logic          scl_t,
  input  logic          sda_i,
  output logic          sda_o,
  output logic          sda_t,
  output logic          busy,
  output logic          wr_strobe,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic [PW-1:0] host_raddr,
  output logic [7:0]    host_rdata
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK
  } state_t;

  logic [1:0] pin_in;
  logic [1:0] line_f;
  logic       scl_f, sda_f;

  assign pin_in = {sda_i, scl_i};
  assign scl_f  = line_f[0];
  assign sda_f  = line_f[1];

  // Each line: 2-FF synchronizer, then accept a new level only after FILTER_LEN equal samples.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_filt
    logic          s1_q, s1_d, s2_q, s2_d, f_q, f_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      s1_d  = pin_in[gi];
      s2_d  = s1_q;
      f_d   = f_q;
      cnt_d = '0;
      if (s2_q != f_q) begin
        if (cnt_q == CW'(FILTER_LEN - 1)) f_d = s2_q;
        else cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q  <= 1'b1;
        s2_q  <= 1'b1;
        f_q   <= 1'b1;
        cnt_q <= '0;
      end else begin
        s1_q  <= s1_d;
        s2_q  <= s2_d;
        f_q   <= f_d;
        cnt_q <= cnt_d;
      end
    end

    assign line_f[gi] = f_q;
  end

  logic scl_p_q, sda_p_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_p_q <= scl_f;
      sda_p_q <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_p_q;
  assign scl_fall  = ~scl_f & scl_p_q;
  assign start_det = scl_f & scl_p_q & sda_p_q & ~sda_f;
  assign stop_det  = scl_f & scl_p_q & ~sda_p_q & sda_f;

  state_t        state_q;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    shreg_q;
  logic          first_q, rw_q;
  logic [PW-1:0] ptr_q;
  logic          sda_t_q, wr_strobe_q;
  logic [PW-1:0] wr_addr_q;
  logic [7:0]    wr_data_q;
  logic [7:0]    regs_q [NUM_REGS];
  logic [7:0]    rx_byte, rd_byte;

  assign rx_byte = {shreg_q[6:0], sda_f};
  assign rd_byte = regs_q[ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      first_q     <= 1'b0;
      rw_q        <= 1'b0;
      ptr_q       <= '0;
      sda_t_q     <= 1'b1;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      if (start_det) begin
        state_q   <= ADDR;
        bit_cnt_q <= '0;
        sda_t_q   <= 1'b1;
      end else if (stop_det) begin
        state_q <= IDLE;
        sda_t_q <= 1'b1;
      end else if (scl_rise) begin
        case (state_q)
          ADDR: begin
            shreg_q   <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_q <= '0;
              rw_q      <= rx_byte[0];
              first_q   <= 1'b1;
              state_q   <= (rx_byte[7:1] == TARGET_ADDR) ? ADDR_ACK : IDLE;
            end
          end
          WR_BYTE: begin
            shreg_q   <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_q <= '0;
              state_q   <= WR_ACK;
              if (first_q) begin
                ptr_q   <= rx_byte[PW-1:0];
                first_q <= 1'b0;
              end else begin
                regs_q[ptr_q] <= rx_byte;
                wr_strobe_q   <= 1'b1;
                wr_addr_q     <= ptr_q;
                wr_data_q     <= rx_byte;
                ptr_q         <= ptr_q + 1'b1;
              end
            end
          end
          RD_BYTE: bit_cnt_q <= bit_cnt_q + 1'b1;
          RD_ACK: begin
            if (sda_f) begin
              state_q <= IDLE;
            end else begin
              shreg_q   <= rd_byte;
              ptr_q     <= ptr_q + 1'b1;
              bit_cnt_q <= '0;
              state_q   <= RD_BYTE;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state_q)
          // bit_cnt 0: fall after bit 8 starts the ACK; bit_cnt 1: fall after bit 9 ends it.
          ADDR_ACK, WR_ACK: begin
            if (bit_cnt_q == 4'd0) begin
              sda_t_q   <= 1'b0;
              bit_cnt_q <= 4'd1;
            end else begin
              bit_cnt_q <= '0;
              if (state_q == ADDR_ACK && rw_q) begin
                sda_t_q <= rd_byte[7];
                shreg_q <= {rd_byte[6:0], 1'b1};
                ptr_q   <= ptr_q + 1'b1;
                state_q <= RD_BYTE;
              end else begin
                sda_t_q <= 1'b1;
                state_q <= WR_BYTE;
              end
            end
          end
          RD_BYTE: begin
            if (bit_cnt_q == 4'd8) begin
              sda_t_q <= 1'b1;
              state_q <= RD_ACK;
            end else begin
              sda_t_q <= shreg_q[7];
              shreg_q <= {shreg_q[6:0], 1'b1};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign scl_o      = 1'b0;
  assign scl_t      = 1'b1;
  assign sda_o      = 1'b0;
  assign sda_t      = sda_t_q;
  assign busy       = (state_q != IDLE);
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign host_rdata = regs_q[host_raddr];

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged I2C controller drives an open-drain bus model;
// register writes are scoreboarded against wr_strobe, read bytes against an expected queue.
module tb_i2c_target_regs;
  localparam int PW = 4;
  localparam int Q  = 10;  // quarter SCL period in clk cycles

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scl_m = 1'b1;
  logic          sda_m = 1'b1;
  logic          scl_o, scl_t, sda_o, sda_t, busy, wr_strobe;
  logic [PW-1:0] wr_addr;
  logic [PW-1:0] host_raddr = '0;
  logic [7:0]    wr_data, host_rdata;
  logic          scl_bus, sda_bus;

  assign scl_bus = scl_m & (scl_t | scl_o);
  assign sda_bus = sda_m & (sda_t | sda_o);

  int          total = 0;
  int          bad = 0;
  logic [11:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic        last_sda_t;

  always #5 clk = ~clk;

  i2c_target_regs #(.TARGET_ADDR(7'h50), .NUM_REGS(16), .FILTER_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .scl_i(scl_bus), .scl_o(scl_o), .scl_t(scl_t),
    .sda_i(sda_bus), .sda_o(sda_o), .sda_t(sda_t),
    .busy(busy), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .host_raddr(host_raddr), .host_rdata(host_rdata)
  );

  // Write scoreboard: every strobe must match the next expected (addr,data).
  always @(negedge clk) begin
    if (rst_n && wr_strobe) begin
      logic [11:0] e;
      total++;
      if (exp_wr.size() == 0) begin
        bad++;
        $display("FAIL wr_strobe_unexpected got addr=%0h data=%02h want none", wr_addr, wr_data);
      end else begin
        e = exp_wr.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          bad++;
          $display("FAIL wr_strobe got addr=%0h data=%02h want addr=%0h data=%02h",
                   wr_addr, wr_data, e[11:8], e[7:0]);
        end else begin
          $display("wr_strobe addr=%0h data=%02h", wr_addr, wr_data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic glitch, output logic smp);
    sda_m = b;
    clks(Q);
    scl_m = 1'b1;
    clks(Q);
    smp = sda_bus;
    last_sda_t = sda_t;
    if (glitch) begin
      clks(3);
      scl_m = 1'b0;
      clks(2);
      scl_m = 1'b1;
      clks(Q - 5);
    end else begin
      clks(Q);
    end
    scl_m = 1'b0;
    clks(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    clks(Q);
    scl_m = 1'b1;
    clks(2 * Q);
    sda_m = 1'b0;
    clks(2 * Q);
    scl_m = 1'b0;
    clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    clks(Q);
    scl_m = 1'b1;
    clks(2 * Q);
    sda_m = 1'b1;
    clks(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input int gbit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], (i == gbit), s);
    send_bit(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    send_bit(nack, 1'b0, s);
  endtask

  task automatic send_bytes(input logic [7:0] b0, input logic [7:0] b1, input int n, input string tag);
    logic ack;
    logic [7:0] bytes [2];
    bytes[0] = b0;
    bytes[1] = b1;
    for (int i = 0; i < n; i++) begin
      write_byte(bytes[i], -1, ack);
      total++;
      if (ack !== 1'b1) begin
        bad++;
        $display("FAIL %s_ack byte=%02h got=%b want=1", tag, bytes[i], ack);
      end else begin
        $display("%s byte %02h acked", tag, bytes[i]);
      end
    end
  endtask

  task automatic check_reg(input logic [PW-1:0] a, input logic [7:0] want, input string tag);
    host_raddr = a;
    #1;
    total++;
    if (host_rdata !== want) begin
      bad++;
      $display("FAIL %s regs[%0h] got=%02h want=%02h", tag, a, host_rdata, want);
    end else begin
      $display("%s regs[%0h]=%02h", tag, a, host_rdata);
    end
  endtask

  task automatic check_idle(input string tag);
    total++;
    if (busy !== 1'b0 || sda_t !== 1'b1 || exp_wr.size() != 0) begin
      bad++;
      $display("FAIL %s_idle got busy=%b sda_t=%b pending_wr=%0d want busy=0 sda_t=1 pending_wr=0",
               tag, busy, sda_t, exp_wr.size());
    end else begin
      $display("%s idle ok", tag);
    end
  endtask

  task automatic test_reset();
    clks(3);
    total++;
    if ({sda_t, busy, wr_strobe, wr_addr, wr_data, scl_t, scl_o, sda_o} !== {1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs got sda_t=%b busy=%b strobe=%b addr=%0h data=%02h scl_t=%b scl_o=%b sda_o=%b want 1 0 0 0 00 1 0 0",
               sda_t, busy, wr_strobe, wr_addr, wr_data, scl_t, scl_o, sda_o);
    end else begin
      $display("reset outputs ok");
    end
    rst_n = 1'b1;
    clks(20);
    check_reg(4'h3, 8'h00, "reset");
    check_idle("reset");
  endtask

  task automatic test_write();
    exp_wr.push_back({4'h3, 8'h5A});
    exp_wr.push_back({4'h4, 8'hA5});
    i2c_start();
    send_bytes(8'hA0, 8'h03, 2, "write");
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL write_busy got=%b want=1", busy);
    end
    send_bytes(8'h5A, 8'hA5, 2, "write");
    i2c_stop();
    clks(Q);
    check_idle("write");
    check_reg(4'h3, 8'h5A, "write");
    check_reg(4'h4, 8'hA5, "write");
  endtask

  task automatic do_read(input logic [7:0] ptr, input logic [7:0] e0, input logic [7:0] e1, input string tag);
    logic [7:0] d;
    logic [7:0] e;
    i2c_start();
    send_bytes(8'hA0, ptr, 2, tag);
    i2c_start();
    send_bytes(8'hA1, 8'h00, 1, tag);
    exp_rd.push_back(e0);
    exp_rd.push_back(e1);
    for (int i = 0; i < 2; i++) begin
      read_byte(i == 1, d);
      e = exp_rd.pop_front();
      total++;
      if (d !== e) begin
        bad++;
        $display("FAIL %s_data byte%0d got=%02h want=%02h", tag, i, d, e);
      end else begin
        $display("%s byte%0d=%02h", tag, i, d);
      end
    end
    total++;
    if (sda_t !== 1'b1 || last_sda_t !== 1'b1) begin
      bad++;
      $display("FAIL %s_nack_release got sda_t=%b at9th=%b want 1 1", tag, sda_t, last_sda_t);
    end
    i2c_stop();
    clks(Q);
    check_idle(tag);
  endtask

  task automatic test_read();
    do_read(8'h03, 8'h5A, 8'hA5, "read");
  endtask

  task automatic test_mismatch();
    logic ack;
    i2c_start();
    write_byte(8'hA2, -1, ack);
    total++;
    if (ack !== 1'b0 || last_sda_t !== 1'b1) begin
      bad++;
      $display("FAIL mismatch_nack got ack=%b sda_t=%b want ack=0 sda_t=1", ack, last_sda_t);
    end else begin
      $display("mismatch address NACKed");
    end
    i2c_stop();
    clks(Q);
    check_idle("mismatch");
  endtask

  task automatic test_wrap();
    exp_wr.push_back({4'hF, 8'h11});
    exp_wr.push_back({4'h0, 8'h22});
    i2c_start();
    send_bytes(8'hA0, 8'h0F, 2, "wrap");
    send_bytes(8'h11, 8'h22, 2, "wrap");
    i2c_stop();
    clks(Q);
    check_idle("wrap");
    check_reg(4'hF, 8'h11, "wrap");
    check_reg(4'h0, 8'h22, "wrap");
  endtask

  task automatic test_back_to_back();
    do_read(8'h0F, 8'h11, 8'h22, "read_wrap");
  endtask

  task automatic test_glitch();
    logic ack;
    exp_wr.push_back({4'h7, 8'hC3});
    i2c_start();
    send_bytes(8'hA0, 8'h07, 2, "glitch");
    write_byte(8'hC3, 4, ack);
    total++;
    if (ack !== 1'b1) begin
      bad++;
      $display("FAIL glitch_ack got=%b want=1", ack);
    end
    i2c_stop();
    clks(Q);
    check_idle("glitch");
    check_reg(4'h7, 8'hC3, "glitch");
  endtask

  task automatic test_reset_mid_read();
    i2c_start();
    send_bytes(8'hA0, 8'h03, 2, "rstread");
    i2c_start();
    send_bytes(8'hA1, 8'h00, 1, "rstread");
    total++;
    if (sda_t !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rstread_driving got sda_t=%b busy=%b want sda_t=0 busy=1", sda_t, busy);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (sda_t !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rstread_async got sda_t=%b busy=%b want sda_t=1 busy=0", sda_t, busy);
    end else begin
      $display("reset mid-read released SDA");
    end
    check_reg(4'h3, 8'h00, "rstread");
    check_reg(4'hF, 8'h00, "rstread");
    scl_m = 1'b1;
    sda_m = 1'b1;
    clks(3);
    rst_n = 1'b1;
    clks(20);
    check_idle("rstread");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_wrap();
    test_back_to_back();
    test_glitch();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
